// File: rtl/ringcount_param_if.sv
// ringcount_param_if: control/status bundle for ringcount_param.
//   master: drives en, mode, dir, load, load_val; observes q, wrap, err.
//   slave : the counter side (inverse directions).
interface ringcount_param_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             err;

  modport master (output en, mode, dir, load, load_val,
                  input  q, wrap, err);
  modport slave  (input  en, mode, dir, load, load_val,
                  output q, wrap, err);
endinterface

// File: rtl/ringcount_param.sv
// ringcount_param: one-hot ring / Johnson (twisted-ring) sequencer with
// direction control, step enable, parallel load, illegal-state correction
// and single-cycle wrap/err pulses. All outputs are flops.
//   clk  : rising-edge clock
//   ori  : synchronous active-low reset (loads the home state of current mode)
//   bus  : slave side of ringcount_param_if
//          en/mode/dir/load/load_val in, q/wrap/err out
// WIDTH must be 2..32 and INIT_POS must lie in 0..WIDTH-1.
module ringcount_param #(
  parameter int WIDTH    = 3,
  parameter int INIT_POS = 0
) (
  input logic               clk,
  input logic               ori,
  ringcount_param_if.slave  bus
);

  typedef logic [WIDTH-1:0] st_t;
  typedef logic [WIDTH-2:0] edg_t;

  localparam st_t RING_HOME = st_t'(1) << INIT_POS;

  st_t  q_q, q_d;
  logic wrap_q, wrap_d;
  logic err_q, err_d;

  st_t  home;
  st_t  shifted;
  edg_t edges;
  logic fb;
  logic ring_ok, john_ok, cur_ok, load_ok;
  logic ld_ring_ok, ld_john_ok;
  edg_t ld_edges;

  always_comb begin
    // Home follows the live mode, so a mode flip retargets correction.
    home = bus.mode ? '0 : RING_HOME;

    // Ring legality: exactly one bit set.
    ring_ok    = (q_q != '0) && ((q_q & (q_q - st_t'(1))) == '0);
    ld_ring_ok = (bus.load_val != '0) &&
                 ((bus.load_val & (bus.load_val - st_t'(1))) == '0);

    // Johnson legality: at most one adjacent-bit transition.
    edges      = q_q[WIDTH-2:0] ^ q_q[WIDTH-1:1];
    john_ok    = (edges & (edges - edg_t'(1))) == '0;
    ld_edges   = bus.load_val[WIDTH-2:0] ^ bus.load_val[WIDTH-1:1];
    ld_john_ok = (ld_edges & (ld_edges - edg_t'(1))) == '0;

    cur_ok  = bus.mode ? john_ok    : ring_ok;
    load_ok = bus.mode ? ld_john_ok : ld_ring_ok;

    // Wrap-around bit, inverted in Johnson mode.
    fb      = (bus.dir ? q_q[0] : q_q[WIDTH-1]) ^ bus.mode;
    shifted = bus.dir ? {fb, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fb};

    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.load) begin
      // Load wins over en; an illegal value is replaced by home.
      q_d   = load_ok ? bus.load_val : home;
      err_d = ~load_ok;
    end else if (bus.en) begin
      if (!cur_ok) begin
        // Correction step: go home without rotating.
        q_d   = home;
        err_d = 1'b1;
      end else begin
        q_d    = shifted;
        wrap_d = (shifted == home);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!ori) begin
      q_q    <= home;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_ringcount_param.sv
// Bench for ringcount_param. u0 (WIDTH=3, INIT_POS=0) runs a directed table
// with hand-derived expectations; u1 (WIDTH=5, INIT_POS=2) runs a reset
// priority check then random stimulus against a behavioural model.
// Expectations are queued at drive time and popped one cycle later.
module tb_ringcount_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ori;

  ringcount_param_if #(.WIDTH(3)) b0 ();
  ringcount_param_if #(.WIDTH(5)) b1 ();

  ringcount_param #(.WIDTH(3), .INIT_POS(0)) u0 (.clk(clk), .ori(ori), .bus(b0.slave));
  ringcount_param #(.WIDTH(5), .INIT_POS(2)) u1 (.clk(clk), .ori(ori), .bus(b1.slave));

  typedef struct {
    string      tag;
    bit         sel;
    logic [4:0] q;
    logic       w;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Monitor: compare one cycle after the edge that consumed the stimulus.
  always @(posedge clk) begin
    exp_t       x;
    logic [6:0] got;
    #1;
    if (sb.size() > 0) begin
      x   = sb.pop_front();
      got = x.sel ? {b1.q, b1.wrap, b1.err} : {2'b00, b0.q, b0.wrap, b0.err};
      chk(x.tag, {25'b0, got}, {25'b0, x.q, x.w, x.e});
    end
  end

  // Directed step on u0 with explicit expectation {q, wrap, err}.
  task automatic d0(input string tag, input bit o, input bit en, input bit m,
                    input bit d, input bit ld, input logic [2:0] lv,
                    input logic [2:0] eq, input bit ew, input bit ee);
    @(negedge clk);
    ori = o; b0.en = en; b0.mode = m; b0.dir = d; b0.load = ld; b0.load_val = lv;
    sb.push_back('{tag: tag, sel: 1'b0, q: {2'b00, eq}, w: ew, e: ee});
  endtask

  // ---- behavioural model for WIDTH=5, INIT_POS=2 ----
  logic [4:0] mq;

  function automatic bit m_legal(input logic [4:0] v, input bit m);
    int c = 0;
    if (!m) begin
      for (int i = 0; i < 5; i++) c += int'(v[i]);
      return c == 1;
    end
    for (int i = 0; i < 4; i++) if (v[i] != v[i+1]) c++;
    return c <= 1;
  endfunction

  function automatic logic [4:0] m_rot(input logic [4:0] v, input bit m, input bit d);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) begin
      if (!d) r[i] = (i == 0) ? (m ? ~v[4] : v[4]) : v[(i+4)%5];
      else    r[i] = (i == 4) ? (m ? ~v[0] : v[0]) : v[(i+1)%5];
    end
    return r;
  endfunction

  function automatic logic [6:0] m_next(input bit o, input bit en, input bit m, input bit d,
                                        input bit ld, input logic [4:0] lv, input logic [4:0] cur);
    logic [4:0] h;
    logic [4:0] nx;
    h = m ? 5'b00000 : 5'b00100;
    if (!o) return {h, 2'b00};
    if (ld) return m_legal(lv, m) ? {lv, 2'b00} : {h, 2'b01};
    if (en) begin
      if (!m_legal(cur, m)) return {h, 2'b01};
      nx = m_rot(cur, m, d);
      return {nx, (nx == h), 1'b0};
    end
    return {cur, 2'b00};
  endfunction

  task automatic d1(input string tag, input bit o, input bit en, input bit m,
                    input bit d, input bit ld, input logic [4:0] lv);
    logic [6:0] r;
    @(negedge clk);
    ori = o; b1.en = en; b1.mode = m; b1.dir = d; b1.load = ld; b1.load_val = lv;
    r  = m_next(o, en, m, d, ld, lv, mq);
    mq = r[6:2];
    sb.push_back('{tag: tag, sel: 1'b1, q: r[6:2], w: r[1], e: r[0]});
  endtask

  initial begin
    bit m, d, o, en, ld;
    ori = 1'b0;
    b0.en = 0; b0.mode = 0; b0.dir = 0; b0.load = 0; b0.load_val = '0;
    b1.en = 0; b1.mode = 0; b1.dir = 0; b1.load = 0; b1.load_val = '0;
    mq = '0;

    //      tag           ori en m d ld lv      q     w e
    d0("rst_ring",       0, 0, 0, 0, 0, 3'b000, 3'b001, 0, 0);
    d0("ring_s1",        1, 1, 0, 0, 0, 3'b000, 3'b010, 0, 0);
    d0("ring_s2",        1, 1, 0, 0, 0, 3'b000, 3'b100, 0, 0);
    d0("ring_wrap",      1, 1, 0, 0, 0, 3'b000, 3'b001, 1, 0);
    d0("ring_s4",        1, 1, 0, 0, 0, 3'b000, 3'b010, 0, 0);
    d0("rst_john",       0, 0, 1, 0, 0, 3'b000, 3'b000, 0, 0);
    d0("john_s1",        1, 1, 1, 0, 0, 3'b000, 3'b001, 0, 0);
    d0("john_s2",        1, 1, 1, 0, 0, 3'b000, 3'b011, 0, 0);
    d0("john_s3",        1, 1, 1, 0, 0, 3'b000, 3'b111, 0, 0);
    d0("john_s4",        1, 1, 1, 0, 0, 3'b000, 3'b110, 0, 0);
    d0("john_s5",        1, 1, 1, 0, 0, 3'b000, 3'b100, 0, 0);
    d0("john_wrap",      1, 1, 1, 0, 0, 3'b000, 3'b000, 1, 0);
    d0("rst_ring2",      0, 0, 0, 0, 0, 3'b000, 3'b001, 0, 0);
    d0("load_bad",       1, 0, 0, 0, 1, 3'b101, 3'b001, 0, 1);
    d0("after_bad",      1, 1, 0, 0, 0, 3'b000, 3'b010, 0, 0);
    d0("load_good",      1, 0, 0, 0, 1, 3'b100, 3'b100, 0, 0);
    d0("ring_wrap2",     1, 1, 0, 0, 0, 3'b000, 3'b001, 1, 0);
    d0("ring_010",       1, 1, 0, 0, 0, 3'b000, 3'b010, 0, 0);
    d0("mode_fix",       1, 1, 1, 0, 0, 3'b000, 3'b000, 0, 1);
    d0("mode_cont",      1, 1, 1, 0, 0, 3'b000, 3'b001, 0, 0);
    d0("john_011",       1, 1, 1, 0, 0, 3'b000, 3'b011, 0, 0);
    d0("dir_flip",       1, 1, 1, 1, 0, 3'b000, 3'b001, 0, 0);
    d0("dir_wrap",       1, 1, 1, 1, 0, 3'b000, 3'b000, 1, 0);
    d0("hold1",          1, 0, 1, 1, 0, 3'b000, 3'b000, 0, 0);
    d0("hold2",          1, 0, 1, 1, 0, 3'b000, 3'b000, 0, 0);
    d0("hold3",          1, 0, 1, 1, 0, 3'b000, 3'b000, 0, 0);
    d0("load_over_en",   1, 1, 1, 0, 1, 3'b011, 3'b011, 0, 0);
    d0("load_bad_john",  1, 1, 1, 0, 1, 3'b101, 3'b000, 0, 1);
    d0("rst_over_load",  0, 1, 0, 0, 1, 3'b010, 3'b001, 0, 0);
    d0("post_rst",       1, 1, 0, 0, 0, 3'b000, 3'b010, 0, 0);
    d0("ring_dn_wrap",   1, 1, 0, 1, 0, 3'b000, 3'b001, 1, 0);
    d0("ring_dn",        1, 1, 0, 1, 0, 3'b000, 3'b100, 0, 0);
    d0("both_legal",     1, 1, 1, 1, 0, 3'b000, 3'b110, 0, 0);
    d0("to_ring_fix",    1, 1, 0, 0, 0, 3'b000, 3'b001, 0, 1);

    // u1: reset beats load and en, then normal stepping resumes.
    d1("w5_rst_prio",    0, 1, 0, 0, 1, 5'b00001);
    d1("w5_resume",      1, 1, 0, 0, 0, 5'b00000);

    m = 0; d = 0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(9) == 0) m = ~m;
      if ($urandom_range(4) == 0) d = ~d;
      o  = ($urandom_range(29) != 0);
      en = ($urandom_range(4) != 0);
      ld = ($urandom_range(9) == 0);
      d1($sformatf("w5_rnd%0d", k), o, en, m, d, ld, 5'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ringcount_param.md
# ringcount_param

Parametrised successor to the three-bit ring counter. Generates a rotating state vector of configurable width in either one-hot ring mode or twisted-ring (Johnson) mode, with direction control, clock enable and parallel load. It also self-corrects illegal states and reports wrap and error events as single-cycle pulses. It is used wherever the design needs a free-running one-hot or Johnson sequencer, such as phase selects or round-robin strobes.

## Interface
- WIDTH, default 3: number of state bits; legal range 2..32.
- INIT_POS, default 0: bit set in the ring-mode home state; must satisfy 0 <= INIT_POS < WIDTH.

- clk  in  1  single clock; all state updates on rising edge.
- ori  in  1  reset/initialise; synchronous, active-low.
- en  in  1  step enable; when high, the counter advances one state per clock.
- mode  in  1  0 = ring (one-hot rotate), 1 = Johnson (inverted feedback).
- dir  in  1  0 = shift toward higher index, 1 = shift toward lower index.
- load  in  1  parallel-load strobe.
- load_val  in  WIDTH  value written by load.
- q  out  WIDTH  counter state; registered.
- wrap  out  1  one-cycle pulse; the last step returned q to the home state.
- err  out  1  one-cycle pulse; the last load or step detected an illegal state and forced home.

## Operation
- Home state H depends on the current `mode`:
  - Ring: H = 1 << INIT_POS.
  - Johnson: H = all zeros.
- Legal states:
  - Ring: exactly one bit of q is set.
  - Johnson: at most one index i in 0..WIDTH-2 with q[i] != q[i+1]. This gives 2*WIDTH legal states.
- Next-state rules, in priority order, evaluated at each rising clk:
  1. ori == 0: q <= H, wrap <= 0, err <= 0.
  2. load == 1:
     - If load_val is legal for the current mode: q <= load_val, err <= 0.
     - Otherwise: q <= H, err <= 1.
     - wrap <= 0 in both cases. `en` is ignored.
  3. en == 1 and q illegal for the current mode: q <= H, err <= 1, wrap <= 0. This is the correction step and does not rotate.
  4. en == 1 and q legal: q <= shift(q), err <= 0, wrap <= (shift(q) == H).
  5. Otherwise: q holds, wrap <= 0, err <= 0.
- shift(q) by mode and direction:
  - Ring, dir 0: q[i] <= q[i-1] for i >= 1; q[0] <= q[WIDTH-1].
  - Ring, dir 1: q[i] <= q[i+1] for i <= WIDTH-2; q[WIDTH-1] <= q[0].
  - Johnson, dir 0: as ring dir 0, except q[0] <= ~q[WIDTH-1].
  - Johnson, dir 1: as ring dir 1, except q[WIDTH-1] <= ~q[0].
- Mode or direction change mid-run:
  - A direction change takes effect on the next step with no glitch; the state stays legal.
  - A mode change makes q illegal in most cases. The next enabled step then corrects q to the new H and pulses err. If q happens to be legal in both modes (for example 001 in ring and in Johnson), the counter simply continues rotating.
- Because rule 1 uses the `mode` sampled in the reset cycle, a reset issued while mode = 1 yields all zeros.

## Timing
- Every output is a flop; there are no combinational paths from inputs to outputs.
- Latency: q reflects a step, load or correction on the clk edge that samples the request, so it is visible one cycle after the request is presented.
- wrap and err are high for exactly one cycle, aligned with the q value that caused them. They never assert together.
- Sustained `en` advances one state per cycle with no bubbles. Period is WIDTH steps in ring mode and 2*WIDTH steps in Johnson mode.
- A reset asserted mid-sequence wins over load and en in the same cycle. The counter restarts from H on the following cycle.
- load and en asserted together: the load wins and the step is dropped.

## Test plan
- Reset, ring, WIDTH=3, INIT_POS=0, dir=0, en=1 -> q = 001, 010, 100, 001, ... with wrap high only on the cycle q returns to 001.
- Johnson, WIDTH=3, dir=0, en=1 from reset -> q = 000, 001, 011, 111, 110, 100, 000; wrap pulses once per 6 steps.
- Ring mode, load 3'b101 -> q = 001 (H), err pulses once; next en step gives 010. Then load 3'b100 -> q = 100, err stays 0.
- Ring mode running at q = 010, switch mode to 1 with en=1 -> 010 is illegal in Johnson, so q becomes 000 with an err pulse; then 001 follows.
- Johnson at q = 011, toggle dir to 1 -> q = 001, then 000 with a wrap pulse; en=0 for 3 cycles holds q with wrap=0 and err=0.
- ori low while load=1 and en=1, mode=0, INIT_POS=2 -> q = 100, wrap=0, err=0; normal stepping resumes on the cycle after ori returns high.
